// File: rtl/mips_bus_pkg.sv
// Shared types, default addresses and helpers for the bus-interface MIPS fetch stage.
package mips_bus_pkg;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEF    = 32'h0000_0000;
  localparam logic [3:0]  BYTEENABLE_ALL   = 4'hF;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    HALTED
  } fetch_state_t;

  // Source of the next PC, chosen by the fetch FSM and applied by ifetch_pc.
  typedef enum logic [1:0] {
    PC_KEEP,
    PC_INC,
    PC_TARGET,
    PC_PEND
  } pc_sel_t;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = w[8*(3-i) +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_pc.sv
// Program counter and deferred-redirect storage for the fetch stage.
// The FSM picks the next-PC source; this block owns the registers and the mux.
module ifetch_pc
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  pc_sel_t       pc_sel_i,
  input  logic          pend_set_i,
  input  logic          pend_clr_i,
  input  logic [31:0]   redirect_target_i,
  output logic [31:0]   pc_o,
  output logic [31:0]   pc_inc_o,
  output logic [31:0]   redir_pc_o,
  output logic          redir_pend_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] target_al;

  assign target_al = word_align(redirect_target_i);
  assign pc_inc_o  = pc_q + 32'd4;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    pc_d         = pc_q;
    redir_pc_d   = redir_pc_q;
    redir_pend_d = redir_pend_q;

    unique case (pc_sel_i)
      PC_INC:    pc_d = pc_inc_o;
      PC_TARGET: pc_d = target_al;
      PC_PEND:   pc_d = redir_pc_q;
      default:   pc_d = pc_q;
    endcase

    // A newer redirect during a stalled read simply overwrites the stored target.
    if (pend_set_i) begin
      redir_pend_d = 1'b1;
      redir_pc_d   = target_al;
    end else if (pend_clr_i) begin
      redir_pend_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= RESET_VECTOR;
      redir_pc_q   <= '0;
      redir_pend_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      redir_pc_q   <= redir_pc_d;
      redir_pend_q <= redir_pend_d;
    end
  end

  assign pc_o         = pc_q;
  assign redir_pc_o   = redir_pc_q;
  assign redir_pend_o = redir_pend_q;

endmodule

// File: rtl/ifetch_bus.sv
// Instruction fetch stage: Avalon-MM read master, holding IR with valid/ready
// handshake towards decode, branch/jump redirects and halt detection.
module ifetch_bus
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEF,
  parameter bit          SWAP_BYTES   = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr_word,
  output logic [31:0] instr_pc,
  output logic        active
);

  fetch_state_t state_q, state_d;
  logic         avm_read_q, avm_read_d;
  logic         instr_valid_q, instr_valid_d;
  logic [31:0]  instr_word_q, instr_pc_q;
  logic         capture;
  pc_sel_t      pc_sel;
  logic         pend_set, pend_clr;
  logic         go_halt;

  logic [31:0]  pc, pc_inc, redir_pc;
  logic         redir_pend;
  logic [31:0]  fetch_word;

  ifetch_pc #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc (
    .clk               (clk),
    .reset_n           (reset_n),
    .pc_sel_i          (pc_sel),
    .pend_set_i        (pend_set),
    .pend_clr_i        (pend_clr),
    .redirect_target_i (redirect_target),
    .pc_o              (pc),
    .pc_inc_o          (pc_inc),
    .redir_pc_o        (redir_pc),
    .redir_pend_o      (redir_pend)
  );

  assign fetch_word = SWAP_BYTES ? bswap32(avm_readdata) : avm_readdata;

  always_comb begin
    state_d       = state_q;
    avm_read_d    = avm_read_q;
    instr_valid_d = instr_valid_q;
    capture       = 1'b0;
    pc_sel        = PC_KEEP;
    pend_set      = 1'b0;
    pend_clr      = 1'b0;
    go_halt       = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (!avm_read_q) begin
          // Only reachable right after reset: no transfer is in flight yet.
          if (redirect_valid)       pc_sel = PC_TARGET;
          else if (pc == HALT_ADDR) state_d = HALTED;
          else                      avm_read_d = 1'b1;
        end else if (!avm_waitrequest) begin
          avm_read_d = 1'b0;
          if (redirect_valid) begin
            pc_sel   = PC_TARGET;
            pend_clr = 1'b1;
          end else if (redir_pend) begin
            pc_sel   = PC_PEND;
            pend_clr = 1'b1;
          end else begin
            capture       = 1'b1;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end else if (redirect_valid) begin
          // The stalled read cannot be aborted; remember where to go once it ends.
          pend_set = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          instr_valid_d = 1'b0;
          pc_sel        = PC_TARGET;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          pc_sel        = PC_INC;
        end
      end
      default: begin
        state_d       = HALTED;
        avm_read_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase

    unique case (pc_sel)
      PC_INC:    go_halt = (pc_inc == HALT_ADDR);
      PC_TARGET: go_halt = (word_align(redirect_target) == HALT_ADDR);
      PC_PEND:   go_halt = (redir_pc == HALT_ADDR);
      default:   go_halt = 1'b0;
    endcase

    // Any PC change restarts fetching, unless the new PC is the halt address.
    if (pc_sel != PC_KEEP) begin
      state_d    = go_halt ? HALTED : FETCH;
      avm_read_d = !go_halt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FETCH;
      avm_read_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_word_q  <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      avm_read_q    <= avm_read_d;
      instr_valid_q <= instr_valid_d;
      if (capture) begin
        instr_word_q <= fetch_word;
        instr_pc_q   <= pc;
      end
    end
  end

  assign avm_address    = pc;
  assign avm_read       = avm_read_q;
  assign avm_byteenable = BYTEENABLE_ALL;
  assign instr_valid    = instr_valid_q;
  assign instr_word     = instr_word_q;
  assign instr_pc       = instr_pc_q;
  assign active         = (state_q != HALTED);

endmodule

// File: tb/tb_ifetch_bus.sv
// Self-checking bench for ifetch_bus: directed cycle table, multi-cycle corner
// sequences, then randomized traffic against an instruction-stream reference model.
module tb_ifetch_bus;

  localparam logic [31:0] B = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wreq = 1'b0;
  logic        rdy = 1'b0;
  logic        rv = 1'b0;
  logic [31:0] tgt = '0;

  logic [31:0] n_addr, n_rd, n_word, n_pc;
  logic        n_read, n_valid, n_active;
  logic [3:0]  n_be;
  logic [31:0] s_addr, s_rd, s_word, s_pc;
  logic        s_read, s_valid, s_active;
  logic [3:0]  s_be;
  logic [31:0] h_addr, h_word, h_pc;
  logic        h_read, h_valid, h_active;
  logic [3:0]  h_be;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2402_0005;
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] swap_ref(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign n_rd = mem_word(n_addr);
  assign s_rd = swap_ref(mem_word(s_addr));

  ifetch_bus dut (
    .clk(clk), .reset_n(reset_n), .avm_address(n_addr), .avm_read(n_read),
    .avm_byteenable(n_be), .avm_waitrequest(wreq), .avm_readdata(n_rd),
    .redirect_valid(rv), .redirect_target(tgt), .instr_ready(rdy),
    .instr_valid(n_valid), .instr_word(n_word), .instr_pc(n_pc), .active(n_active)
  );

  ifetch_bus #(.SWAP_BYTES(1'b1)) dut_swap (
    .clk(clk), .reset_n(reset_n), .avm_address(s_addr), .avm_read(s_read),
    .avm_byteenable(s_be), .avm_waitrequest(wreq), .avm_readdata(s_rd),
    .redirect_valid(rv), .redirect_target(tgt), .instr_ready(rdy),
    .instr_valid(s_valid), .instr_word(s_word), .instr_pc(s_pc), .active(s_active)
  );

  ifetch_bus #(.RESET_VECTOR(32'h0000_1000), .HALT_ADDR(32'h0000_1000)) dut_halt (
    .clk(clk), .reset_n(reset_n), .avm_address(h_addr), .avm_read(h_read),
    .avm_byteenable(h_be), .avm_waitrequest(wreq), .avm_readdata(32'h0),
    .redirect_valid(rv), .redirect_target(tgt), .instr_ready(rdy),
    .instr_valid(h_valid), .instr_word(h_word), .instr_pc(h_pc), .active(h_active)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        w;
    logic        r;
    logic        redir;
    logic [31:0] t;
  } vec_t;

  vec_t vecs[22];

  task automatic set_vec(input int i, input logic er, input logic [31:0] ea, input logic ev,
                         input logic [31:0] ep, input logic w, input logic r,
                         input logic redir, input logic [31:0] t);
    vecs[i].e_read  = er;
    vecs[i].e_addr  = ea;
    vecs[i].e_valid = ev;
    vecs[i].e_pc    = ep;
    vecs[i].w       = w;
    vecs[i].r       = r;
    vecs[i].redir   = redir;
    vecs[i].t       = t;
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic [31:0] rnd;
    logic        prev_stall;
    int          wait_run, idle, max_idle, delivered;

    // Row = outputs expected at this falling edge, then inputs driven for the next rising edge.
    set_vec( 0, 0, B,          0, 0,          0, 1, 0, 0);
    set_vec( 1, 1, B,          0, 0,          0, 1, 0, 0);
    set_vec( 2, 0, B,          1, B,          0, 1, 0, 0);
    set_vec( 3, 1, B+4,        0, 0,          1, 1, 0, 0);
    set_vec( 4, 1, B+4,        0, 0,          1, 1, 0, 0);
    set_vec( 5, 1, B+4,        0, 0,          1, 1, 0, 0);
    set_vec( 6, 1, B+4,        0, 0,          0, 1, 0, 0);
    set_vec( 7, 0, B+4,        1, B+4,        0, 0, 0, 0);
    set_vec( 8, 0, B+4,        1, B+4,        0, 0, 0, 0);
    set_vec( 9, 0, B+4,        1, B+4,        0, 0, 0, 0);
    set_vec(10, 0, B+4,        1, B+4,        0, 0, 0, 0);
    set_vec(11, 0, B+4,        1, B+4,        0, 1, 0, 0);
    set_vec(12, 1, B+8,        0, 0,          1, 1, 1, B+32'h100);
    set_vec(13, 1, B+8,        0, 0,          1, 1, 0, 0);
    set_vec(14, 1, B+8,        0, 0,          0, 1, 0, 0);
    set_vec(15, 1, B+32'h100,  0, 0,          0, 1, 0, 0);
    set_vec(16, 0, B+32'h100,  1, B+32'h100,  0, 1, 0, 0);
    set_vec(17, 1, B+32'h104,  0, 0,          0, 1, 0, 0);
    set_vec(18, 0, B+32'h104,  1, B+32'h104,  0, 1, 1, B+32'h202);
    set_vec(19, 1, B+32'h200,  0, 0,          0, 1, 0, 0);
    set_vec(20, 0, B+32'h200,  1, B+32'h200,  0, 1, 0, 0);
    set_vec(21, 1, B+32'h204,  0, 0,          0, 1, 0, 0);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("t%0d_read", i), n_read, vecs[i].e_read);
      check($sformatf("t%0d_addr", i), n_addr, vecs[i].e_addr);
      check($sformatf("t%0d_valid", i), n_valid, vecs[i].e_valid);
      check($sformatf("t%0d_active", i), n_active, 1);
      check($sformatf("t%0d_swap_valid", i), s_valid, vecs[i].e_valid);
      check($sformatf("t%0d_halt_read", i), h_read, 0);
      check($sformatf("t%0d_halt_active", i), h_active, (i == 0) ? 1 : 0);
      if (vecs[i].e_valid) begin
        check($sformatf("t%0d_pc", i), n_pc, vecs[i].e_pc);
        check($sformatf("t%0d_word", i), n_word, mem_word(vecs[i].e_pc));
        check($sformatf("t%0d_swap_word", i), s_word, mem_word(vecs[i].e_pc));
      end
      if (i == 0) reset_n = 1'b1;
      wreq = vecs[i].w;
      rdy  = vecs[i].r;
      rv   = vecs[i].redir;
      tgt  = vecs[i].t;
    end

    // Redirect to a misaligned halt address: stage must stop for good.
    @(negedge clk);
    check("pre_halt_valid", n_valid, 1);
    check("pre_halt_pc", n_pc, B + 32'h204);
    rv = 1'b1; tgt = 32'h0000_0003; rdy = 1'b0;
    @(negedge clk);
    rv = 1'b0;
    check("halt_active", n_active, 0);
    check("halt_read", n_read, 0);
    check("halt_valid", n_valid, 0);
    for (int i = 0; i < 6; i++) begin
      wreq = 1'($urandom_range(0, 1));
      rdy  = 1'($urandom_range(0, 1));
      rv   = 1'($urandom_range(0, 1));
      tgt  = B + 32'h40;
      @(negedge clk);
      check("halted_read", n_read, 0);
      check("halted_valid", n_valid, 0);
      check("halted_active", n_active, 0);
    end

    // Async reset in the middle of a stalled read.
    rv = 1'b0; wreq = 1'b0; rdy = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pre_read", n_read, 1);
    check("rst_pre_addr", n_addr, B + 4);
    wreq = 1'b1;
    @(negedge clk);
    check("rst_stall_addr", n_addr, B + 4);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_read", n_read, 0);
    check("rst_async_addr", n_addr, B);
    check("rst_async_valid", n_valid, 0);
    check("rst_async_active", n_active, 1);
    @(negedge clk);
    reset_n = 1'b1;
    wreq = 1'b0;
    @(negedge clk);
    check("rst_restart_read", n_read, 1);
    check("rst_restart_addr", n_addr, B);
    @(negedge clk);
    check("rst_restart_valid", n_valid, 1);
    check("rst_restart_word", n_word, 32'h2402_0005);

    // Randomized traffic: model tracks only which PC must be presented next.
    exp_pc = B;
    prev_stall = 1'b0;
    prev_addr = '0;
    wait_run = 0; idle = 0; max_idle = 0; delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      wreq = (wait_run < 3) && ($urandom_range(0, 2) == 0);
      wait_run = wreq ? wait_run + 1 : 0;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rnd = 32'($urandom_range(0, 4095));
      tgt = B + (rnd << 2) + 32'($urandom_range(0, 3));
      if (rv) begin
        exp_pc = {tgt[31:2], 2'b00};
        idle = 0;
      end else if (n_valid && rdy) begin
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      prev_stall = n_read && wreq;
      prev_addr  = n_addr;
      @(negedge clk);
      if (n_valid) idle = 0;
      else begin
        idle++;
        if (idle > max_idle) max_idle = idle;
      end
      check("rnd_active", n_active, 1);
      check("rnd_byteenable", n_be, 4'hF);
      check("rnd_addr_align", n_addr[1:0], 2'b00);
      check("rnd_read_in_hold", n_read & n_valid, 0);
      check("rnd_swap_valid", s_valid, n_valid);
      if (prev_stall) begin
        check("rnd_stall_read", n_read, 1);
        check("rnd_stall_addr", n_addr, prev_addr);
      end
      if (n_valid) begin
        check("rnd_pc", n_pc, exp_pc);
        check("rnd_word", n_word, mem_word(exp_pc));
        check("rnd_swap_word", s_word, mem_word(exp_pc));
      end
    end
    check("rnd_delivered_ge_200", delivered >= 200, 1);
    check("rnd_idle_le_16", max_idle <= 16, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
